mux_rr_arbiter: RTL

//  Round-robin arbiter that shares one 8:1 bit-select mux lane among 8 requesters.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types, sizes and helpers for the round-robin lane arbiter
package mux_arb_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary index of a one-hot vector; zero vector maps to index 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - circular first-set search starting at a given index
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  input  logic [SEL_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Walk start, start+1, ... wrapping mod NREQ; the masked index (current owner) is skipped.
  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && req[cand] && !(mask_en && (cand == mask_idx))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbitration for a shared 8:1 bit-select lane
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             dout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   gnt_d;
  logic [SEL_W-1:0]  sel_d;
  logic              busy_d;

  logic [SEL_W-1:0]  owner;
  logic [SEL_W-1:0]  pick_start;
  logic              pick_mask_en;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  assign owner = onehot_to_idx(gnt);

  // While granting, search after the owner and never re-pick it; when idle, search from ptr.
  always_comb begin
    pick_start   = ptr_q;
    pick_mask_en = 1'b0;
    if (state_q == GRANT) begin
      pick_start   = owner + SEL_W'(1);
      pick_mask_en = 1'b1;
    end
  end

  rr_priority_pick u_pick (
    .req      (req),
    .start    (pick_start),
    .mask_idx (owner),
    .mask_en  (pick_mask_en),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Next-state, hold counter and grant decisions.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
          ptr_d   = pick_idx + SEL_W'(1);
        end
      end
      GRANT: begin
        if (req[owner] && (!pick_found || (hold_q != HOLD_LAST))) begin
          // Owner keeps the lane; the counter saturates so a lone owner is never evicted.
          if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
        end else if (pick_found) begin
          // Either the hold budget ran out under contention or the owner let go.
          gnt_d  = NREQ'(1) << pick_idx;
          sel_d  = pick_idx;
          busy_d = 1'b1;
          hold_d = '0;
          ptr_d  = pick_idx + SEL_W'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // Control and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
    end
  end

  // Registered mux stage: the current owner's bit, one cycle behind the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 1'b0;
    end else begin
      dout <= busy ? din[sel] : 1'b0;
    end
  end

endmodule
